hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 3-stage core (F / D-E / M-W). It sits beside the forwarding datapath.
- Decides forwarding, load-use stalls, control-transfer flushes, interrupt entry and mret return.
- Drives the PC select mux, the F/D hold and flush controls, the E/M bubble control and the mepc capture enable.

Parameters:
- WIDTH, 32, instruction/data width.
- IRQ_DRAIN_CYC, 2, cycles spent in IRQ_DRAIN before vectoring; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-high reset.
- inst_f2d  input  WIDTH  instruction in decode/execute stage.
- inst_e2m  input  WIDTH  instruction in memory/writeback stage.
- reg_wr_mw  input  1  M-W instruction writes the register file.
- mem_ready  input  1  data-memory read data valid this cycle.
- br_taken  input  1  branch in D-E resolved taken.
- irq_req  input  1  level interrupt request.
- stall_if  output  1  hold PC.
- stall_id  output  1  hold F/D register.
- flush_id  output  1  zero F/D register (NOP).
- flush_e2m  output  1  inject bubble into E/M.
- pc_sel  output  2  00 pc+4, 01 branch/jump target, 10 mtvec, 11 mepc.
- forward_ae  output  1  rs1 operand from M-W result.
- forward_be  output  1  rs2 operand from M-W result.
- epc_we  output  1  capture current D-E pc into mepc.
- irq_ack  output  1  one-cycle interrupt accept pulse.

Behaviour:
- Field decode:
  - rd_e2m = inst_e2m[11:7]; rs1 = inst_f2d[19:15]; rs2 = inst_f2d[24:20].
  - load_e2m = (inst_e2m[6:0] == 7'h03).
  - mret_e2m = (inst_e2m == 32'h30200073).
  - jump_f2d = opcode 7'h6f or 7'h67.
- hit_a = reg_wr_mw & rd_e2m != 0 & rd_e2m == rs1. hit_b is the same against rs2. hit_a and hit_b are evaluated independently; both may assert.
- States: RUN, LD_STALL, IRQ_DRAIN, IRQ_ENTER. Registered: state, drain_cnt[3:0], in_handler.
- Outputs are combinational from state and inputs. While rst_n is high every output is 0; state = RUN, drain_cnt = 0, in_handler = 0.
- RUN, priority highest first:
  1. mret_e2m: pc_sel=11, flush_id=1, clear in_handler.
  2. jump_f2d | br_taken: pc_sel=01, flush_id=1, forwards 0.
  3. irq_req & !in_handler: flush_id=1, stall_if=1, drain_cnt<=0, go IRQ_DRAIN.
  4. load_e2m & (hit_a | hit_b): stall_if=stall_id=1, flush_e2m=1, go LD_STALL.
  5. Otherwise forward_ae=hit_a, forward_be=hit_b, pc_sel=00.
- LD_STALL:
  - stall_if=stall_id=1, flush_e2m=1.
  - mem_ready=1 → RUN next cycle; decode re-reads the written-back register (regfile write-first).
  - irq_req is held off and re-evaluated in RUN.
- IRQ_DRAIN:
  - stall_if=1, flush_id=1, drain_cnt increments.
  - At drain_cnt == IRQ_DRAIN_CYC-1 → IRQ_ENTER.
  - br_taken/jump are ignored, since D-E holds a NOP.
- IRQ_ENTER (exactly 1 cycle): epc_we=1, pc_sel=10, irq_ack=1, set in_handler → RUN.
- Simultaneous events:
  - Branch and irq in the same cycle: redirect first; irq accepted the next RUN cycle.
  - Branch and load-use in the same cycle: flush only, no stall.
  - mret and irq in the same cycle: mret serviced, irq accepted the following cycle.
- irq_req deassertion during IRQ_DRAIN does not abort entry.
- Reset asserted mid-stall or mid-drain returns to RUN immediately, with no irq_ack.

Optional Feature:
- Macro HAZARD_CTRL_LOAD_FWD_EN.
- Defined: in RUN, a load-use hit with mem_ready=1 in the same cycle forwards directly (forward_ae/be = hits), with no LD_STALL and no bubble.
- Undefined: every load-use hit costs at least one LD_STALL cycle.

Decomposition:
- Shared package pipeline_pkg:
  - ctrl_state_e enum.
  - pc_sel_e (PC_PLUS4, PC_TARGET, PC_MTVEC, PC_MEPC).
  - Constants OPC_JAL 7'h6f, OPC_JALR 7'h67, OPC_LOAD 7'h03, OPC_BRANCH 7'h63, INST_MRET 32'h30200073.
- One combinational sub-module hazard_detect: field decode plus hit_a/hit_b/load_use/jump/mret. The FSM stays in hazard_ctrl.

Test Plan:
- inst_e2m=add x5 (0x00000293-type, rd=5), reg_wr_mw=1, inst_f2d=add x6,x5,x7 → forward_ae=1, forward_be=0, no stall.
- inst_e2m=lw x5, inst_f2d uses x5 as rs2, mem_ready low 2 cycles then high → stall_if/stall_id/flush_e2m high 3 cycles, then RUN. With HAZARD_CTRL_LOAD_FWD_EN and mem_ready=1 → forward_be=1, no stall.
- inst_f2d=jal (opcode 0x6f) with a register hit present → flush_id=1, pc_sel=01, forward_ae=0.
- irq_req=1 in RUN, IRQ_DRAIN_CYC=2 → 2 drain cycles (stall_if=1), then 1 cycle epc_we=irq_ack=1, pc_sel=10. A second irq_req is ignored until inst_e2m=0x30200073, which gives pc_sel=11.
- br_taken=1 and irq_req=1 same cycle → pc_sel=01 first; drain starts the next cycle.
- rst_n pulsed high during LD_STALL → all outputs 0 asynchronously; state RUN after release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and opcode constants for the 3-stage core's sequencing control.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LD_STALL  = 2'b01,
        IRQ_DRAIN = 2'b10,
        IRQ_ENTER = 2'b11
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_MTVEC  = 2'b10,
        PC_MEPC   = 2'b11
    } pc_sel_e;

    localparam logic [6:0]  OPC_JAL    = 7'h6f;
    localparam logic [6:0]  OPC_JALR   = 7'h67;
    localparam logic [6:0]  OPC_LOAD   = 7'h03;
    localparam logic [6:0]  OPC_BRANCH = 7'h63;
    localparam logic [31:0] INST_MRET  = 32'h30200073;

endpackage

// File: rtl/hazard_detect.sv
// Combinational field decode: M-W -> D-E register hits, load-use, jump and mret detection.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] inst_f2d,
    input  logic [WIDTH-1:0] inst_e2m,
    input  logic             reg_wr_mw,
    output logic             hit_a,
    output logic             hit_b,
    output logic             load_use,
    output logic             jump_f2d,
    output logic             mret_e2m
);

    logic [4:0] rd_e2m;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] opc_f2d;
    logic       load_e2m;
    logic       unused_f2d;

    assign rd_e2m   = inst_e2m[11:7];
    assign rs1      = inst_f2d[19:15];
    assign rs2      = inst_f2d[24:20];
    assign opc_f2d  = inst_f2d[6:0];
    assign load_e2m = (inst_e2m[6:0] == OPC_LOAD);

    // x0 is never a real producer, so it can never forward
    assign hit_a = reg_wr_mw && (rd_e2m != 5'd0) && (rd_e2m == rs1);
    assign hit_b = reg_wr_mw && (rd_e2m != 5'd0) && (rd_e2m == rs2);

    assign load_use = load_e2m && (hit_a || hit_b);
    assign jump_f2d = (opc_f2d == OPC_JAL) || (opc_f2d == OPC_JALR);
    assign mret_e2m = (inst_e2m == WIDTH'(INST_MRET));

    assign unused_f2d = ^{inst_f2d[WIDTH-1:25], inst_f2d[14:7]};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing FSM: forwarding, load-use stall, redirect flush, irq entry, mret.
// Optional macro HAZARD_CTRL_LOAD_FWD_EN: forward a load result ready in the same cycle.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int IRQ_DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inst_f2d,
    input  logic [WIDTH-1:0] inst_e2m,
    input  logic             reg_wr_mw,
    input  logic             mem_ready,
    input  logic             br_taken,
    input  logic             irq_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_e2m,
    output logic [1:0]       pc_sel,
    output logic             forward_ae,
    output logic             forward_be,
    output logic             epc_we,
    output logic             irq_ack
);

    localparam logic [3:0] DRAIN_LAST = 4'(IRQ_DRAIN_CYC - 1);

    ctrl_state_e state, state_nxt;
    logic [3:0]  drain_cnt, drain_cnt_nxt;
    logic        in_handler, in_handler_nxt;
    pc_sel_e     pc_mux;

    logic hit_a, hit_b, load_use, jump_f2d, mret_e2m;

    hazard_detect #(.WIDTH(WIDTH)) u_detect (
        .inst_f2d  (inst_f2d),
        .inst_e2m  (inst_e2m),
        .reg_wr_mw (reg_wr_mw),
        .hit_a     (hit_a),
        .hit_b     (hit_b),
        .load_use  (load_use),
        .jump_f2d  (jump_f2d),
        .mret_e2m  (mret_e2m)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= RUN;
            drain_cnt  <= 4'd0;
            in_handler <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_cnt_nxt;
            in_handler <= in_handler_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        in_handler_nxt = in_handler;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        flush_id       = 1'b0;
        flush_e2m      = 1'b0;
        forward_ae     = 1'b0;
        forward_be     = 1'b0;
        epc_we         = 1'b0;
        irq_ack        = 1'b0;
        pc_mux         = PC_PLUS4;

        unique case (state)
            RUN: begin
                if (mret_e2m) begin
                    pc_mux         = PC_MEPC;
                    flush_id       = 1'b1;
                    in_handler_nxt = 1'b0;
                end else if (jump_f2d || br_taken) begin
                    pc_mux   = PC_TARGET;
                    flush_id = 1'b1;
                end else if (irq_req && !in_handler) begin
                    flush_id      = 1'b1;
                    stall_if      = 1'b1;
                    drain_cnt_nxt = 4'd0;
                    state_nxt     = IRQ_DRAIN;
`ifdef HAZARD_CTRL_LOAD_FWD_EN
                end else if (load_use && !mem_ready) begin
`else
                end else if (load_use) begin
`endif
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    flush_e2m = 1'b1;
                    state_nxt = LD_STALL;
                end else begin
                    // a ready load result takes this path too when same-cycle forwarding is built in
                    forward_ae = hit_a;
                    forward_be = hit_b;
                end
            end
            LD_STALL: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                flush_e2m = 1'b1;
                if (mem_ready) begin
                    state_nxt = RUN;
                end
            end
            IRQ_DRAIN: begin
                stall_if      = 1'b1;
                flush_id      = 1'b1;
                drain_cnt_nxt = drain_cnt + 4'd1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = IRQ_ENTER;
                end
            end
            IRQ_ENTER: begin
                epc_we         = 1'b1;
                irq_ack        = 1'b1;
                pc_mux         = PC_MTVEC;
                in_handler_nxt = 1'b1;
                state_nxt      = RUN;
            end
            default: state_nxt = RUN;
        endcase

        // outputs are held quiet for as long as reset is asserted
        if (rst_n) begin
            stall_if   = 1'b0;
            stall_id   = 1'b0;
            flush_id   = 1'b0;
            flush_e2m  = 1'b0;
            forward_ae = 1'b0;
            forward_be = 1'b0;
            epc_we     = 1'b0;
            irq_ack    = 1'b0;
            pc_mux     = PC_PLUS4;
        end
        pc_sel = pc_mux;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one task per scenario, expected output vectors queued at drive time.
module tb_hazard_ctrl;

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] ADDI_X5   = 32'h00000293;
    localparam logic [31:0] LW_X5     = 32'h0000A283;
    localparam logic [31:0] ADD_A_X5  = 32'h00728333;
    localparam logic [31:0] ADD_B_X5  = 32'h00508333;
    localparam logic [31:0] ADD_AB_X5 = 32'h00528333;
    localparam logic [31:0] ADD_X1X1  = 32'h00108333;
    localparam logic [31:0] ADD_X0X0  = 32'h00000333;
    localparam logic [31:0] JAL_X5    = 32'h000280EF;
    localparam logic [31:0] JALR_X5   = 32'h00028067;
    localparam logic [31:0] BEQ_X5    = 32'h00028063;
    localparam logic [31:0] MRET      = 32'h30200073;

    // {stall_if, stall_id, flush_id, flush_e2m, pc_sel[1:0], fwd_a, fwd_b, epc_we, irq_ack}
    localparam logic [9:0] E_IDLE  = 10'b0000000000;
    localparam logic [9:0] E_LDS   = 10'b1101000000;
    localparam logic [9:0] E_TGT   = 10'b0010010000;
    localparam logic [9:0] E_IRQ   = 10'b1010000000;
    localparam logic [9:0] E_ENTER = 10'b0000100011;
    localparam logic [9:0] E_MRET  = 10'b0010110000;
    localparam logic [9:0] E_FA    = 10'b0000001000;
    localparam logic [9:0] E_FB    = 10'b0000000100;
    localparam logic [9:0] E_FAB   = 10'b0000001100;

    typedef struct packed {
        logic [31:0] f2d;
        logic [31:0] e2m;
        logic        wr;
        logic        rdy;
        logic        br;
        logic        irq;
        logic        pulse;
        logic [9:0]  ex;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_f2d, inst_e2m;
    logic        reg_wr_mw, mem_ready, br_taken, irq_req;
    logic        stall_if, stall_id, flush_id, flush_e2m;
    logic [1:0]  pc_sel;
    logic        forward_ae, forward_be, epc_we, irq_ack;

    logic [9:0]  sb[$];
    logic [9:0]  got, want;
    int          n_cmp = 0;
    int          n_bad = 0;
    wire  [9:0]  obs = {stall_if, stall_id, flush_id, flush_e2m, pc_sel,
                        forward_ae, forward_be, epc_we, irq_ack};

    always #5 clk = ~clk;

    hazard_ctrl #(.WIDTH(32), .IRQ_DRAIN_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_f2d   (inst_f2d),
        .inst_e2m   (inst_e2m),
        .reg_wr_mw  (reg_wr_mw),
        .mem_ready  (mem_ready),
        .br_taken   (br_taken),
        .irq_req    (irq_req),
        .stall_if   (stall_if),
        .stall_id   (stall_id),
        .flush_id   (flush_id),
        .flush_e2m  (flush_e2m),
        .pc_sel     (pc_sel),
        .forward_ae (forward_ae),
        .forward_be (forward_be),
        .epc_we     (epc_we),
        .irq_ack    (irq_ack)
    );

    function automatic vec_t mkv(input logic [31:0] f2d, input logic [31:0] e2m,
                                 input logic wr, input logic rdy, input logic br,
                                 input logic irq, input logic pulse, input logic [9:0] ex);
        vec_t v;
        v.f2d = f2d; v.e2m = e2m; v.wr = wr; v.rdy = rdy;
        v.br = br; v.irq = irq; v.pulse = pulse; v.ex = ex;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        inst_f2d  = v.f2d;
        inst_e2m  = v.e2m;
        reg_wr_mw = v.wr;
        mem_ready = v.rdy;
        br_taken  = v.br;
        irq_req   = v.irq;
        sb.push_back(v.ex);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_IDLE));
        #2;
        got = obs; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL reset_held got=%b want=%b", got, want);
        end
        @(negedge clk);
        rst_n = 1'b0;
        drive(mkv(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        #2;
        got = obs; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL reset_release got=%b want=%b", got, want);
        end
        @(negedge clk);
    endtask

    task automatic test_forward();
        vec_t v[$];
        v.push_back(mkv(ADD_A_X5,  ADDI_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_FA));
        v.push_back(mkv(ADD_B_X5,  ADDI_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_FB));
        v.push_back(mkv(ADD_AB_X5, ADDI_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_FAB));
        v.push_back(mkv(ADD_AB_X5, ADDI_X5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        v.push_back(mkv(ADD_X0X0,  NOP,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        v.push_back(mkv(ADD_X1X1,  ADDI_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        foreach (v[i]) begin
            drive(v[i]);
            #2;
            got = obs; want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL forward[%0d] got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        vec_t v[$];
        v.push_back(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LDS));
        v.push_back(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_LDS));
        v.push_back(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_LDS));
        v.push_back(mkv(ADD_B_X5, NOP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
`ifdef HAZARD_CTRL_LOAD_FWD_EN
        v.push_back(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_FB));
        v.push_back(mkv(ADD_B_X5, NOP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
`else
        v.push_back(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_LDS));
        v.push_back(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_LDS));
        v.push_back(mkv(ADD_B_X5, NOP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
`endif
        foreach (v[i]) begin
            drive(v[i]);
            #2;
            got = obs; want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump();
        vec_t v[$];
        v.push_back(mkv(JAL_X5,  ADDI_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_TGT));
        v.push_back(mkv(JALR_X5, ADDI_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_TGT));
        v.push_back(mkv(BEQ_X5,  ADDI_X5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_TGT));
        v.push_back(mkv(BEQ_X5,  LW_X5,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_TGT));
        v.push_back(mkv(NOP,     NOP,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        v.push_back(mkv(BEQ_X5,  ADDI_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_FA));
        foreach (v[i]) begin
            drive(v[i]);
            #2;
            got = obs; want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL jump[%0d] got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_irq();
        vec_t v[$];
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IRQ));
        v.push_back(mkv(JAL_X5, NOP,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ENTER));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE));
        v.push_back(mkv(NOP,    MRET, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_MRET));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ENTER));
        v.push_back(mkv(NOP,    MRET, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MRET));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        foreach (v[i]) begin
            drive(v[i]);
            #2;
            got = obs; want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL irq[%0d] got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_irq();
        vec_t v[$];
        v.push_back(mkv(BEQ_X5, NOP,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_TGT));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ENTER));
        v.push_back(mkv(NOP,    MRET, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MRET));
        v.push_back(mkv(NOP,    NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        foreach (v[i]) begin
            drive(v[i]);
            #2;
            got = obs; want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL branch_irq[%0d] got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    // reset pulses land between edges, so only the asynchronous path can clear the FSM
    task automatic test_reset_mid();
        vec_t v[$];
        v.push_back(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LDS));
        v.push_back(mkv(ADD_B_X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_LDS));
        v.push_back(mkv(ADD_B_X5, NOP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        v.push_back(mkv(NOP,      NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IRQ));
        v.push_back(mkv(NOP,      NOP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_IRQ));
        v.push_back(mkv(NOP,      NOP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        v.push_back(mkv(NOP,      NOP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        v.push_back(mkv(NOP,      NOP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
        foreach (v[i]) begin
            drive(v[i]);
            #2;
            got = obs; want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL reset_mid[%0d] got=%b want=%b", i, got, want);
            end
            if (v[i].pulse) begin
                #1;
                rst_n    = 1'b1;
                inst_e2m = NOP;
                irq_req  = 1'b0;
                sb.push_back(E_IDLE);
                #1;
                got = obs; want = sb.pop_front(); n_cmp++;
                if (got !== want) begin
                    n_bad++; $display("FAIL reset_mid_pulse[%0d] got=%b want=%b", i, got, want);
                end
                rst_n = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        inst_f2d  = NOP;
        inst_e2m  = NOP;
        reg_wr_mw = 1'b0;
        mem_ready = 1'b0;
        br_taken  = 1'b0;
        irq_req   = 1'b0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_jump();
        test_irq();
        test_branch_irq();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
